// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a registered-read instruction memory and fills the IF/ID register.
// A one-entry skid buffer keeps the word returned during a stall so nothing is lost or repeated.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid
);

   logic [31:0] fetch_pc;
   logic [31:0] resp_pc;
   logic        resp_valid;
   logic [31:0] hold_instr;
   logic        hold_valid;

   logic [31:0] resp_instr;
   logic [31:0] next_instr;

   assign imem_addr = fetch_pc;

   // The held copy wins: after a stall the memory is already returning the following word.
   always_comb begin
      resp_instr = imem_rdata;
      next_instr = 32'h0000_0000;
      if (hold_valid) begin
         resp_instr = hold_instr;
      end
      if (resp_valid) begin
         next_instr = resp_instr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= 32'h0000_0000;
         resp_valid  <= 1'b0;
         hold_instr  <= 32'h0000_0000;
         hold_valid  <= 1'b0;
         if_id_instr <= 32'h0000_0000;
         if_id_pc    <= 32'h0000_0000;
         if_id_pc4   <= 32'h0000_0000;
         if_id_valid <= 1'b0;
      end else if (redirect_valid) begin
         // Redirect beats stall so the older wrong-path word is squashed.
         fetch_pc    <= {redirect_target[31:2], 2'b00};
         resp_valid  <= 1'b0;
         hold_valid  <= 1'b0;
         if_id_valid <= 1'b0;
         if_id_instr <= 32'h0000_0000;
      end else if (stall) begin
         if (!hold_valid) begin
            hold_instr <= imem_rdata;
            hold_valid <= 1'b1;
         end
      end else begin
         if_id_instr <= next_instr;
         if_id_pc    <= resp_pc;
         if_id_pc4   <= resp_pc + 32'd4;
         if_id_valid <= resp_valid;
         resp_pc     <= fetch_pc;
         resp_valid  <= 1'b1;
         fetch_pc    <= fetch_pc + 32'd4;
         hold_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stalls, redirects, PC wrap and reset during a stall.
// Memory stubs return word i = 32'h1000_0000 + i with 64-word index truncation.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;

   logic        reset_b;
   logic        stall_b = 1'b0;
   logic        redirect_valid_b = 1'b0;
   logic [31:0] redirect_target_b = 32'h0;
   logic [31:0] imem_addr_b;
   logic [31:0] imem_rdata_b;
   logic [31:0] if_id_instr_b;
   logic [31:0] if_id_pc_b;
   logic [31:0] if_id_pc4_b;
   logic        if_id_valid_b;

   int checks = 0;
   int errors = 0;
   int pat [8] = '{1, 0, 1, 1, 0, 1, 0, 0};

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
      .if_id_valid(if_id_valid)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .reset(reset_b), .stall(stall_b),
      .redirect_valid(redirect_valid_b), .redirect_target(redirect_target_b),
      .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
      .if_id_instr(if_id_instr_b), .if_id_pc(if_id_pc_b), .if_id_pc4(if_id_pc4_b),
      .if_id_valid(if_id_valid_b)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000_0000 + {26'd0, a[7:2]};
   endfunction

   always_ff @(posedge clk) begin
      imem_rdata   <= mem_word(imem_addr);
      imem_rdata_b <= mem_word(imem_addr_b);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; reset_b = 1'b1; stall = 1'b0;
      redirect_valid = 1'b0; redirect_target = 32'h0;
      #2;
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, 32'h0); end
      checks++; if ({if_id_instr, if_id_pc, if_id_pc4, if_id_valid} !== 97'd0) begin errors++;
         $display("FAIL reset_ifid got %h %h %h %b exp all zero", if_id_instr, if_id_pc, if_id_pc4, if_id_valid); end
      step; step;
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_held_valid got %b exp 0", if_id_valid); end
      checks++; if (imem_addr_b !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_addr_wrap got %h exp fffffff8", imem_addr_b); end
      $display("reset: addr=%h valid=%b", imem_addr, if_id_valid);
   endtask

   task automatic test_sequential;
      logic [31:0] exp_pc;
      reset = 1'b0;
      step;
      checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin errors++;
         $display("FAIL seq_edge1 got valid=%b instr=%h exp valid=0 instr=0", if_id_valid, if_id_instr); end
      for (int i = 0; i < 3; i++) begin
         step;
         exp_pc = 32'(4 * i);
         checks++; if (if_id_valid !== 1'b1 || if_id_pc !== exp_pc || if_id_pc4 !== exp_pc + 32'd4 ||
                       if_id_instr !== 32'h1000_0000 + 32'(i)) begin errors++;
            $display("FAIL seq_edge%0d got v=%b pc=%h pc4=%h instr=%h exp pc=%h", i + 2, if_id_valid, if_id_pc, if_id_pc4, if_id_instr, exp_pc); end
         $display("seq: pc=%h instr=%h valid=%b", if_id_pc, if_id_instr, if_id_valid);
      end
   endtask

   task automatic test_stall;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step;
         checks++; if (if_id_pc !== 32'd8 || if_id_instr !== 32'h1000_0002 || if_id_valid !== 1'b1 || imem_addr !== 32'd16) begin errors++;
            $display("FAIL stall_hold%0d got pc=%h instr=%h v=%b addr=%h exp pc=8 instr=10000002 addr=10", i, if_id_pc, if_id_instr, if_id_valid, imem_addr); end
         $display("stall: pc=%h instr=%h", if_id_pc, if_id_instr);
      end
      stall = 1'b0;
      step;
      checks++; if (if_id_pc !== 32'd12 || if_id_instr !== 32'h1000_0003 || if_id_valid !== 1'b1) begin errors++;
         $display("FAIL stall_release got pc=%h instr=%h v=%b exp pc=0000000c instr=10000003", if_id_pc, if_id_instr, if_id_valid); end
      step;
      checks++; if (if_id_pc !== 32'd16 || if_id_instr !== 32'h1000_0004) begin errors++;
         $display("FAIL stall_after got pc=%h instr=%h exp pc=00000010 instr=10000004", if_id_pc, if_id_instr); end
      $display("stall release: pc=%h instr=%h", if_id_pc, if_id_instr);
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp_pc;
      exp_pc = 32'd16;
      for (int i = 0; i < 8; i++) begin
         stall = pat[i][0];
         step;
         if (pat[i] == 0) exp_pc = exp_pc + 32'd4;
         checks++; if (if_id_pc !== exp_pc || if_id_instr !== mem_word(exp_pc) || if_id_valid !== 1'b1) begin errors++;
            $display("FAIL b2b_cycle%0d got pc=%h instr=%h v=%b exp pc=%h instr=%h", i, if_id_pc, if_id_instr, if_id_valid, exp_pc, mem_word(exp_pc)); end
         $display("b2b: stall=%0d pc=%h instr=%h", pat[i], if_id_pc, if_id_instr);
      end
      stall = 1'b0;
   endtask

   task automatic test_redirect;
      reset = 1'b1;
      step;
      reset = 1'b0;
      step; step; step;
      checks++; if (if_id_pc !== 32'd4 || if_id_valid !== 1'b1) begin errors++;
         $display("FAIL redir_setup got pc=%h v=%b exp pc=4 v=1", if_id_pc, if_id_valid); end
      redirect_valid = 1'b1; redirect_target = 32'h0000_0043;
      step;
      redirect_valid = 1'b0;
      checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || imem_addr !== 32'h40) begin errors++;
         $display("FAIL redir_edge got v=%b instr=%h addr=%h exp v=0 instr=0 addr=40", if_id_valid, if_id_instr, imem_addr); end
      step;
      checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin errors++;
         $display("FAIL redir_bubble got v=%b instr=%h exp v=0 instr=0", if_id_valid, if_id_instr); end
      step;
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40 || if_id_pc4 !== 32'h44 || if_id_instr !== 32'h1000_0010) begin errors++;
         $display("FAIL redir_target got v=%b pc=%h pc4=%h instr=%h exp pc=40 pc4=44 instr=10000010", if_id_valid, if_id_pc, if_id_pc4, if_id_instr); end
      step;
      checks++; if (if_id_pc !== 32'h44 || if_id_instr !== 32'h1000_0011) begin errors++;
         $display("FAIL redir_next got pc=%h instr=%h exp pc=44 instr=10000011", if_id_pc, if_id_instr); end
      $display("redirect: pc=%h instr=%h", if_id_pc, if_id_instr);
   endtask

   task automatic test_redirect_stall;
      stall = 1'b1;
      step;
      redirect_valid = 1'b1; redirect_target = 32'h0000_0020;
      step;
      stall = 1'b0; redirect_valid = 1'b0;
      checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || imem_addr !== 32'h20) begin errors++;
         $display("FAIL rs_edge got v=%b instr=%h addr=%h exp v=0 instr=0 addr=20", if_id_valid, if_id_instr, imem_addr); end
      step;
      checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin errors++;
         $display("FAIL rs_bubble got v=%b instr=%h exp v=0 instr=0", if_id_valid, if_id_instr); end
      step;
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h20 || if_id_instr !== 32'h1000_0008) begin errors++;
         $display("FAIL rs_target got v=%b pc=%h instr=%h exp pc=20 instr=10000008", if_id_valid, if_id_pc, if_id_instr); end
      step;
      checks++; if (if_id_pc !== 32'h24 || if_id_instr !== 32'h1000_0009) begin errors++;
         $display("FAIL rs_next got pc=%h instr=%h exp pc=24 instr=10000009", if_id_pc, if_id_instr); end
      $display("redirect+stall: pc=%h instr=%h", if_id_pc, if_id_instr);
   endtask

   task automatic test_wrap;
      reset_b = 1'b0;
      step;
      checks++; if (if_id_valid_b !== 1'b0) begin errors++; $display("FAIL wrap_edge1 got v=%b exp 0", if_id_valid_b); end
      step;
      checks++; if (if_id_pc_b !== 32'hFFFF_FFF8 || if_id_pc4_b !== 32'hFFFF_FFFC || if_id_instr_b !== 32'h1000_003E || if_id_valid_b !== 1'b1) begin errors++;
         $display("FAIL wrap_first got pc=%h pc4=%h instr=%h v=%b exp pc=fffffff8 pc4=fffffffc instr=1000003e", if_id_pc_b, if_id_pc4_b, if_id_instr_b, if_id_valid_b); end
      step;
      checks++; if (if_id_pc_b !== 32'hFFFF_FFFC || if_id_pc4_b !== 32'h0 || if_id_instr_b !== 32'h1000_003F) begin errors++;
         $display("FAIL wrap_top got pc=%h pc4=%h instr=%h exp pc=fffffffc pc4=0 instr=1000003f", if_id_pc_b, if_id_pc4_b, if_id_instr_b); end
      step;
      checks++; if (if_id_pc_b !== 32'h0 || if_id_pc4_b !== 32'h4 || if_id_instr_b !== 32'h1000_0000) begin errors++;
         $display("FAIL wrap_zero got pc=%h pc4=%h instr=%h exp pc=0 pc4=4 instr=10000000", if_id_pc_b, if_id_pc4_b, if_id_instr_b); end
      $display("wrap: pc=%h pc4=%h instr=%h", if_id_pc_b, if_id_pc4_b, if_id_instr_b);
   endtask

   task automatic test_reset_mid_stall;
      stall = 1'b1;
      step; step;
      #1;
      reset = 1'b1;
      #1;
      checks++; if ({if_id_instr, if_id_pc, if_id_pc4, if_id_valid} !== 97'd0 || imem_addr !== 32'h0) begin errors++;
         $display("FAIL rst_async got instr=%h pc=%h pc4=%h v=%b addr=%h exp all zero", if_id_instr, if_id_pc, if_id_pc4, if_id_valid, imem_addr); end
      step;
      reset = 1'b0; stall = 1'b0;
      step;
      checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin errors++;
         $display("FAIL rst_edge1 got v=%b instr=%h exp v=0 instr=0", if_id_valid, if_id_instr); end
      step;
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== 32'h1000_0000) begin errors++;
         $display("FAIL rst_edge2 got v=%b pc=%h instr=%h exp v=1 pc=0 instr=10000000", if_id_valid, if_id_pc, if_id_instr); end
      step;
      checks++; if (if_id_pc !== 32'h4 || if_id_instr !== 32'h1000_0001) begin errors++;
         $display("FAIL rst_edge3 got pc=%h instr=%h exp pc=4 instr=10000001", if_id_pc, if_id_instr); end
      $display("reset mid-stall: pc=%h instr=%h", if_id_pc, if_id_instr);
   endtask

   initial begin
      test_reset;
      test_sequential;
      test_stall;
      test_back_to_back;
      test_redirect;
      test_redirect_stall;
      test_wrap;
      test_reset_mid_stall;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit, meaning the system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, meaning reset, asynchronous, active-high.
REQ-004 SHALL have port stall, input, 1 bit, meaning a hazard-unit request to freeze fetch and the IF/ID register.
REQ-005 SHALL have port redirect_valid, input, 1 bit, meaning a taken branch or jump from a later stage.
REQ-006 SHALL have port redirect_target, input, 32 bits, meaning the new fetch address when redirect_valid=1.
REQ-007 SHALL have port imem_addr, output, 32 bits, meaning the byte address to instruction memory, driven directly from the fetch_pc register.
REQ-008 SHALL have port imem_rdata, input, 32 bits, meaning the instruction memory's registered read data, valid one cycle after its address.
REQ-009 SHALL have port if_id_instr, output, 32 bits, meaning the IF/ID instruction.
REQ-010 SHALL have port if_id_pc, output, 32 bits, meaning the address of if_id_instr.
REQ-011 SHALL have port if_id_pc4, output, 32 bits, meaning if_id_pc+4.
REQ-012 SHALL have port if_id_valid, output, 1 bit, meaning the IF/ID slot holds a real instruction; 0 means bubble.

Function
REQ-013 SHALL keep internal registers fetch_pc (address in flight to memory), resp_pc/resp_valid (address and validity of the word on imem_rdata this cycle), and hold_instr/hold_valid (skid buffer).
REQ-014 SHALL, per edge with stall=0 and redirect_valid=0, do all of the following:
 - IF/ID <= {hold_valid ? hold_instr : imem_rdata, resp_pc, resp_pc+4, resp_valid}
 - resp_pc <= fetch_pc
 - resp_valid <= 1
 - fetch_pc <= fetch_pc+4
 - hold_valid <= 0
REQ-015 SHALL give a latency of 2 edges from fetch_pc presented on imem_addr to the corresponding if_id_valid=1, with no stall.
REQ-016 SHALL, per edge with stall=1 and redirect_valid=0, hold fetch_pc, resp_pc, resp_valid and all IF/ID outputs.
REQ-017 SHALL, on an edge with stall=1, redirect_valid=0 and hold_valid=0, capture imem_rdata into hold_instr and set hold_valid=1; later stall edges SHALL NOT overwrite hold_instr.
REQ-018 SHALL ensure that no instruction is dropped or duplicated across a stall of any length, including a 1-cycle stall and back-to-back stalls.
REQ-019 SHALL, per edge with redirect_valid=1, regardless of stall, do all of the following:
 - fetch_pc <= {redirect_target[31:2],2'b00}
 - resp_valid <= 0
 - hold_valid <= 0
 - if_id_valid <= 0
 - if_id_instr <= 0
REQ-020 SHALL give redirect priority over stall, so the older wrong-path instruction is squashed.
REQ-021 SHALL have the first valid IF/ID of the target appear 2 edges after the redirect edge.
REQ-022 SHALL compute fetch_pc+4 and resp_pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-023 SHALL NOT apply any memory-size wrap; memory index truncation is the memory's concern.
REQ-024 SHALL drive if_id_instr=0 whenever if_id_valid=0 after reset or redirect, so downstream decodes a bubble as NOP.

Reset
REQ-025 SHALL, while reset=1, immediately set fetch_pc=RESET_PC, resp_pc=0, resp_valid=0, hold_valid=0, hold_instr=0, if_id_instr=0, if_id_pc=0, if_id_pc4=0 and if_id_valid=0.
REQ-026 SHALL, for reset asserted mid-stall or mid-redirect, discard all in-flight and held instructions; the first edge after release behaves as REQ-014 with resp_valid=0.
REQ-027 SHALL have the first valid IF/ID after release appear at the 2nd rising edge, with if_id_pc=RESET_PC.

Verification
REQ-028 SHALL be covered by a bench scenario: memory preloaded with word i = 32'h1000_0000+i, reset released, no stall -> IF/ID shows (pc 0, 1000_0000), (pc 4, 1000_0001), (pc 8, 1000_0002) on edges 2, 3, 4.
REQ-029 SHALL be covered by a bench scenario: stall=1 for 3 cycles while if_id_pc=8 -> if_id_pc stays 8 for 3 edges, then the next IF/ID is pc 12 with data 1000_0003, with no gap or repeat.
REQ-030 SHALL be covered by a bench scenario: redirect_valid=1, target 32'h0000_0043, at if_id_pc=4 -> next edge if_id_valid=0; 2 edges later IF/ID is pc 0x40 with data 1000_0010.
REQ-031 SHALL be covered by a bench scenario: redirect_valid=1 and stall=1 in the same cycle, target 0x20 -> behaves exactly as redirect; hold buffer emptied; pc 0x20 appears 2 edges later.
REQ-032 SHALL be covered by a bench scenario: RESET_PC=32'hFFFF_FFF8 -> IF/ID pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; if_id_pc4 at FFFF_FFFC is 0.
REQ-033 SHALL be covered by a bench scenario: reset asserted mid-stall with hold_valid=1 -> all outputs 0 asynchronously; after release, pc RESET_PC appears at edge 2.
